pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch program-counter generator; successor to the single-cycle PC register.
//  Produces the fetch PC with a valid/ready handshake to the fetch stage.
//  Arbitrates trap redirect, branch/jump redirect, return prediction and sequential increment.
//  Supports stall (ready low), halt, configurable reset vector and instruction size.
// PARAMETERS
//  XLEN          32        address/PC width in bits
//  RESET_VECTOR  32'h0     PC value loaded on reset
//  INSTR_BYTES   4         sequential increment; power of two, >=2
//  RAS_DEPTH     4         return-address-stack entries (PC_RAS_EN only); power of two, >=2
// PORTS
//  clk              in   1     clock, rising edge
//  reset            in   1     asynchronous, active-high reset
//  pc_o             out  XLEN  current fetch PC
//  pc_valid_o       out  1     pc_o valid for fetch
//  pc_ready_i       in   1     fetch accepts pc_o this cycle (accept = valid & ready)
//  halt_i           in   1     enter HALT after current cycle
//  trap_valid_i     in   1     trap redirect request
//  trap_target_i    in   XLEN  trap handler address
//  br_valid_i       in   1     branch/jump taken redirect
//  br_base_i        in   XLEN  branch base address (PC of branch or rs1)
//  br_offset_i      in   XLEN  signed two's-complement offset
//  call_i           in   1     instruction at pc_o is a call (predecode)
//  ret_i            in   1     instruction at pc_o is a return (predecode)
//  misaligned_o     out  1     pc_o[log2(INSTR_BYTES)-1:0] != 0, registered with pc_o
// BEHAVIOUR
//  reset (async, any time incl. mid-stall/mid-halt): pc_o=RESET_VECTOR, pc_valid_o=0,
//    misaligned_o=0, state=BOOT, RAS emptied.
//  FSM: BOOT -> RUN unconditionally next cycle (pc_valid_o=1 from then on, pc_o unchanged).
//    RUN -> HALT when halt_i=1 and no redirect that cycle; HALT: pc_valid_o=0, pc_o held.
//    HALT -> RUN on trap_valid_i or br_valid_i (target loaded, pc_valid_o=1 next cycle).
//    halt_i and redirect same cycle: redirect wins, stay RUN.
//  Next-PC priority, evaluated every RUN cycle, registered (latency 1 cycle):
//    1 trap_valid_i          -> trap_target_i
//    2 br_valid_i            -> br_base_i + br_offset_i
//    3 accept & ret predict  -> RAS top (PC_RAS_EN, RAS non-empty)
//    4 accept                -> pc_o + INSTR_BYTES
//    5 otherwise             -> pc_o held (stall); pc_valid_o stays 1
//  Redirects take effect regardless of pc_ready_i; no bubble inserted.
//  Arithmetic: all sums modulo 2^XLEN (0xFFFFFFFC+4 -> 0x0); target LSBs never forced.
//  misaligned_o computed from the next-PC value and registered alongside pc_o.
//  Trap/branch inputs ignored in BOOT; valid/target sampled only when *_valid_i=1.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry circular return-address stack.
//    accept & call_i: push pc_o+INSTR_BYTES; full: overwrite oldest, count saturates.
//    accept & ret_i: pop, next PC = popped value; empty: fall back to sequential.
//    call_i & ret_i together: pop then push (top replaced), next PC = old top.
//    any redirect that cycle suppresses push/pop; trap_valid_i also empties RAS.
//  PC_RAS_EN undefined: call_i/ret_i ignored (ports kept), priority 3 absent, no RAS storage.
// STRUCTURE
//  pc_pkg: pc_state_e {PC_BOOT, PC_RUN, PC_HALT}; next_sel_e {SEL_TRAP, SEL_BR,
//    SEL_RAS, SEL_SEQ, SEL_HOLD}; localparam ALIGN_BITS = $clog2(INSTR_BYTES).
//  Sub-module pc_ras (DEPTH, XLEN): push/pop/flush, top_o, empty_o, full_o;
//    instantiated only under `ifdef PC_RAS_EN.
//  pc_gen: FSM, next-PC mux, PC/misaligned registers.
// TESTING
//  1 reset, release, ready=1 -> cycle0 valid=0 pc=0; then pc 0,4,8,0xC, valid=1.
//  2 ready=0 for 3 cycles at pc=0x10 -> pc held 0x10, valid=1; ready=1 -> 0x14.
//  3 trap(0x100) + br(base 0x20, off 0xFFFFFFF0) same cycle -> pc=0x100 next cycle.
//  4 br base 0xFFFFFFF8 off 0x10 -> pc=0x8 (wrap); off 0x2 from 0x40 -> pc=0x42, misaligned_o=1.
//  5 halt_i at pc=0x30 -> valid=0, pc=0x30 held; br 0x80 -> valid=1, pc=0x80.
//  6 PC_RAS_EN: call at 0x40, ret at 0x200 -> pc=0x44; 5 calls then 5 rets (depth 4) ->
//    4 predicted targets, 5th ret sequential; reset mid-stall -> pc=RESET_VECTOR, valid=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_BR,
        SEL_RAS,
        SEL_SEQ,
        SEL_HOLD
    } next_sel_e;

    // Number of PC low bits that must be zero for an aligned fetch address.
    function automatic int unsigned align_bits(int unsigned bytes);
        return $clog2(bytes);
    endfunction

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam int unsigned ALIGN_BITS      = align_bits(INSTR_BYTES_DEF);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the occupancy count saturates. Push and pop together replace
// the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign top_o   = mem[ptr];
    assign do_pop  = pop_i & ~empty_o;

    // Entry storage: replace top on pop+push, otherwise write above top.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            if (do_pop) begin
                mem[ptr] <= push_data_i;
            end else begin
                mem[PTR_W'(ptr + 1'b1)] <= push_data_i;
            end
        end
    end

    // Top pointer and occupancy; flush only clears the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (push_i && !do_pop) begin
            ptr <= PTR_W'(ptr + 1'b1);
            if (!full_o) begin
                count <= CNT_W'(count + 1'b1);
            end
        end else if (do_pop && !push_i) begin
            ptr   <= PTR_W'(ptr - 1'b1);
            count <= CNT_W'(count - 1'b1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with valid/ready handshake.
// Priority: trap > branch > return prediction > sequential > hold.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = 1 << ALIGN_BITS,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            halt_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            br_valid_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] br_offset_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic            misaligned_o
);

    localparam int unsigned     ALIGN_W = align_bits(INSTR_BYTES);
    localparam logic [XLEN-1:0] INC     = XLEN'(INSTR_BYTES);

    if (!is_pow2(INSTR_BYTES) || INSTR_BYTES < 2) begin : g_bad_instr_bytes
        $error("pc_gen: INSTR_BYTES must be a power of two >= 2");
    end
    if (!is_pow2(RAS_DEPTH) || RAS_DEPTH < 2) begin : g_bad_ras_depth
        $error("pc_gen: RAS_DEPTH must be a power of two >= 2");
    end

    pc_state_e       state, state_next;
    next_sel_e       sel;
    logic [XLEN-1:0] pc_q, pc_next, seq_pc;
    logic            mis_q;
    logic            accept, redirect, ras_pop;

    assign pc_o         = pc_q;
    assign misaligned_o = mis_q;
    assign accept       = pc_valid_o & pc_ready_i;
    assign redirect     = (state != PC_BOOT) & (trap_valid_i | br_valid_i);
    assign seq_pc       = pc_q + INC;

`ifdef PC_RAS_EN
    logic            ras_push, ras_flush, ras_empty, ras_full_unused, ras_ok;
    logic [XLEN-1:0] ras_top;

    // Prediction only acts on an accepted, unredirected, non-halting RUN cycle.
    assign ras_ok    = (state == PC_RUN) & accept & ~redirect & ~halt_i;
    assign ras_pop   = ras_ok & ret_i & ~ras_empty;
    assign ras_push  = ras_ok & call_i;
    assign ras_flush = redirect & trap_valid_i;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .flush_i     (ras_flush),
        .push_data_i (seq_pc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full_unused)
    );
`else
    logic unused_predecode;
    assign unused_predecode = ^{call_i, ret_i};
    assign ras_pop          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PC_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a redirect overrides a simultaneous halt request.
    always_comb begin
        state_next = state;
        case (state)
            PC_BOOT: state_next = PC_RUN;
            PC_RUN:  if (halt_i && !redirect) state_next = PC_HALT;
            PC_HALT: if (redirect) state_next = PC_RUN;
            default: state_next = PC_BOOT;
        endcase
    end

    // Handshake output is purely a function of state.
    always_comb begin
        pc_valid_o = (state == PC_RUN);
    end

    // Next-PC source select; a halting cycle holds pc so it resumes intact.
    always_comb begin
        sel = SEL_HOLD;
        case (state)
            PC_RUN: begin
                if (trap_valid_i)    sel = SEL_TRAP;
                else if (br_valid_i) sel = SEL_BR;
                else if (halt_i)     sel = SEL_HOLD;
                else if (ras_pop)    sel = SEL_RAS;
                else if (accept)     sel = SEL_SEQ;
            end
            PC_HALT: begin
                if (trap_valid_i)    sel = SEL_TRAP;
                else if (br_valid_i) sel = SEL_BR;
            end
            default: sel = SEL_HOLD;
        endcase
    end

    // Next-PC mux; all sums wrap modulo 2^XLEN.
    always_comb begin
        pc_next = pc_q;
        case (sel)
            SEL_TRAP: pc_next = trap_target_i;
            SEL_BR:   pc_next = br_base_i + br_offset_i;
`ifdef PC_RAS_EN
            SEL_RAS:  pc_next = ras_top;
`endif
            SEL_SEQ:  pc_next = seq_pc;
            default:  pc_next = pc_q;
        endcase
    end

    // PC and alignment flag registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_next;
            mis_q <= |pc_next[ALIGN_W-1:0];
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (define PC_RAS_EN to cover the RAS).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_target_i = '0;
    logic        br_valid_i = 1'b0;
    logic [31:0] br_base_i = '0;
    logic [31:0] br_offset_i = '0;
    logic        call_i = 1'b0;
    logic        ret_i = 1'b0;
    logic        misaligned_o;

    int checks = 0;
    int failures = 0;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .pc_ready_i    (pc_ready_i),
        .halt_i        (halt_i),
        .trap_valid_i  (trap_valid_i),
        .trap_target_i (trap_target_i),
        .br_valid_i    (br_valid_i),
        .br_base_i     (br_base_i),
        .br_offset_i   (br_offset_i),
        .call_i        (call_i),
        .ret_i         (ret_i),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_ready_i = 1'b1;
        step();
        checks++;
        if ({pc_valid_o, misaligned_o, pc_o} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_hold valid=%b mis=%b pc=%h exp valid=0 mis=0 pc=0", pc_valid_o, misaligned_o, pc_o);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL boot_cycle valid=%b pc=%h exp valid=0 pc=0", pc_valid_o, pc_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({pc_valid_o, pc_o} !== {1'b1, exp_pc[i]}) begin
                failures++;
                $display("FAIL seq_%0d valid=%b pc=%h exp valid=1 pc=%h", i, pc_valid_o, pc_o, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        pc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_valid_o, pc_o} !== {1'b1, 32'h10}) begin
                failures++;
                $display("FAIL stall_%0d valid=%b pc=%h exp valid=1 pc=00000010", i, pc_valid_o, pc_o);
            end
        end
        pc_ready_i = 1'b1;
        step();
        checks++;
        if (pc_o !== 32'h14) begin
            failures++;
            $display("FAIL stall_release pc=%h exp 00000014", pc_o);
        end
    endtask

    task automatic test_trap_priority();
        trap_valid_i = 1'b1;
        trap_target_i = 32'h100;
        br_valid_i = 1'b1;
        br_base_i = 32'h20;
        br_offset_i = 32'hFFFF_FFF0;
        pc_ready_i = 1'b0;
        step();
        trap_valid_i = 1'b0;
        br_valid_i = 1'b0;
        pc_ready_i = 1'b1;
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b1, 32'h100}) begin
            failures++;
            $display("FAIL trap_over_br valid=%b pc=%h exp valid=1 pc=00000100", pc_valid_o, pc_o);
        end
    endtask

    task automatic test_branch_wrap();
        logic [31:0] base [3] = '{32'hFFFF_FFF8, 32'h40, 32'h50};
        logic [31:0] off  [3] = '{32'h10, 32'h2, 32'h0};
        logic [31:0] exp_pc [3] = '{32'h8, 32'h42, 32'h50};
        logic        exp_mis [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            br_valid_i = 1'b1;
            br_base_i = base[i];
            br_offset_i = off[i];
            step();
            br_valid_i = 1'b0;
            checks++;
            if ({misaligned_o, pc_o} !== {exp_mis[i], exp_pc[i]}) begin
                failures++;
                $display("FAIL branch_%0d pc=%h mis=%b exp pc=%h mis=%b", i, pc_o, misaligned_o, exp_pc[i], exp_mis[i]);
            end
        end
    endtask

    task automatic test_halt();
        br_valid_i = 1'b1;
        br_base_i = 32'h30;
        br_offset_i = 32'h0;
        step();
        br_valid_i = 1'b0;
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b0, 32'h30}) begin
            failures++;
            $display("FAIL halt_enter valid=%b pc=%h exp valid=0 pc=00000030", pc_valid_o, pc_o);
        end
        step();
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b0, 32'h30}) begin
            failures++;
            $display("FAIL halt_hold valid=%b pc=%h exp valid=0 pc=00000030", pc_valid_o, pc_o);
        end
        br_valid_i = 1'b1;
        br_base_i = 32'h80;
        step();
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b1, 32'h80}) begin
            failures++;
            $display("FAIL halt_exit valid=%b pc=%h exp valid=1 pc=00000080", pc_valid_o, pc_o);
        end
        br_base_i = 32'h90;
        halt_i = 1'b1;
        step();
        br_valid_i = 1'b0;
        halt_i = 1'b0;
        step();
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b1, 32'h94}) begin
            failures++;
            $display("FAIL halt_vs_redirect valid=%b pc=%h exp valid=1 pc=00000094", pc_valid_o, pc_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        pc_ready_i = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_valid_o, misaligned_o, pc_o} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL async_reset valid=%b mis=%b pc=%h exp valid=0 mis=0 pc=0", pc_valid_o, misaligned_o, pc_o);
        end
        @(negedge clk);
        reset = 1'b0;
        trap_valid_i = 1'b1;
        trap_target_i = 32'h300;
        step();
        trap_valid_i = 1'b0;
        pc_ready_i = 1'b1;
        checks++;
        if ({pc_valid_o, pc_o} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL boot_ignores_trap valid=%b pc=%h exp valid=1 pc=0", pc_valid_o, pc_o);
        end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_ret [5] = '{32'h1014, 32'h1010, 32'h100C, 32'h1008, 32'h100C};
        br_valid_i = 1'b1;
        br_base_i = 32'h40;
        br_offset_i = 32'h0;
        step();
        br_valid_i = 1'b0;
        call_i = 1'b1;
        step();
        call_i = 1'b0;
        br_valid_i = 1'b1;
        br_base_i = 32'h200;
        step();
        br_valid_i = 1'b0;
        ret_i = 1'b1;
        step();
        ret_i = 1'b0;
        checks++;
        if (pc_o !== 32'h44) begin
            failures++;
            $display("FAIL ras_call_ret pc=%h exp 00000044", pc_o);
        end
        br_valid_i = 1'b1;
        br_base_i = 32'h1000;
        step();
        br_valid_i = 1'b0;
        call_i = 1'b1;
        repeat (5) step();
        call_i = 1'b0;
        ret_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pc_o !== exp_ret[i]) begin
                failures++;
                $display("FAIL ras_ret_%0d pc=%h exp %h", i, pc_o, exp_ret[i]);
            end
        end
        ret_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_trap_priority();
        test_branch_wrap();
        test_halt();
        test_reset_mid_stall();
`ifdef PC_RAS_EN
        test_ras();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
